// File: rtl/seq_ctrl_pkg.sv
// rtl/seq_ctrl_pkg.sv - shared types and LUT entry layout for sequencer_ctrl
package seq_ctrl_pkg;

  localparam int LUT_ENTRY_W = 29;

  localparam int SOF_BIT = 28;
  localparam int EOF_BIT = 27;
  localparam int LEN_LSB = 11;
  localparam int LEN_W   = 16;
  localparam int REP_LSB = 3;
  localparam int REP_W   = 8;
  localparam int NS_LSB  = 0;
  localparam int NS_W    = 3;

  typedef logic [LUT_ENTRY_W-1:0] lut_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_POST  = 3'd3,
    ST_RUN   = 3'd4,
    ST_FAULT = 3'd5
  } ctrl_state_e;

  typedef enum logic [2:0] {
    SEQ_RST          = 3'd0,
    SEQ_IDLE         = 3'd1,
    SEQ_PANEL_STABLE = 3'd2,
    SEQ_BACK_BIAS    = 3'd3,
    SEQ_INTEGRATE    = 3'd4,
    SEQ_READ_SETUP   = 3'd5,
    SEQ_SETTLE       = 3'd6,
    SEQ_READOUT      = 3'd7
  } seq_state_e;

  function automatic lut_entry_t pack_entry(input logic sof, input logic eof,
                                            input logic [LEN_W-1:0] len,
                                            input logic [REP_W-1:0] rep,
                                            input seq_state_e ns);
    lut_entry_t e;
    e = '0;
    e[SOF_BIT] = sof;
    e[EOF_BIT] = eof;
    e[LEN_LSB +: LEN_W] = len;
    e[REP_LSB +: REP_W] = rep;
    e[NS_LSB +: NS_W] = ns;
    return e;
  endfunction

endpackage

// File: rtl/seq_ctrl_shadow_ram.sv
// rtl/seq_ctrl_shadow_ram.sv - shadow LUT buffer, registered write, async read
module seq_ctrl_shadow_ram
  import seq_ctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  lut_entry_t               wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output lut_entry_t               rdata_o
);

  lut_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sequencer_ctrl.sv
// rtl/sequencer_ctrl.sv - LUT load and run lifecycle controller for sequencer_fsm
// Optional RUN watchdog with FAULT state: SEQ_CTRL_WATCHDOG_EN
module sequencer_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int LUT_DEPTH   = 16,
  parameter int PRE_HOLD    = 4,
  parameter int POST_HOLD   = 2,
  parameter int WDOG_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  lut_entry_t  cfg_data_i,
  input  logic        clear_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [15:0] frame_count_i,
  output logic        seq_reset_o,
  output logic        seq_lut_wen_o,
  output lut_entry_t  seq_lut_wdata_o,
  input  logic        seq_done_i,
  output logic [2:0]  state_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] frames_done_o
);

  localparam int AW   = $clog2(LUT_DEPTH);
  localparam int CW   = AW + 1;
  localparam int HMAX = (PRE_HOLD > POST_HOLD) ? PRE_HOLD : POST_HOLD;
  localparam int HW   = $clog2(HMAX) + 1;

  ctrl_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d, ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   target_q, target_d, frames_q, frames_d;
  logic          error_q, error_d, done_q, done_d;
  logic          seq_reset_q, seq_reset_d, wen_q, wen_d;
  lut_entry_t    wdata_q, wdata_d, rd_data;
  logic          wr_acc, start_ok, launch, wd_expired;

  assign cfg_ready_o = (state_q == ST_IDLE) && (count_q < CW'(LUT_DEPTH));
  assign wr_acc      = cfg_valid_i && cfg_ready_o;
  assign start_ok    = start_i && !abort_i;

  seq_ctrl_shadow_ram #(.DEPTH(LUT_DEPTH)) u_shadow (
    .clk     (clk),
    .we_i    (wr_acc && !clear_i),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (cfg_data_i),
    .raddr_i (ptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

`ifdef SEQ_CTRL_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES);
  logic [WW-1:0] wd_q, wd_d;

  // Counter only advances while RUN sees no completion, so it restarts on RUN entry.
  always_comb begin
    wd_d = '0;
    if (state_q == ST_RUN && !seq_done_i) wd_d = wd_q + WW'(1);
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) wd_q <= '0;
    else            wd_q <= wd_d;
  end

  assign wd_expired = (state_q == ST_RUN) && !seq_done_i && (wd_q == WW'(WDOG_CYCLES - 1));
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES != 0);
  assign wd_expired  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
      target_q    <= '0;
      frames_q    <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      seq_reset_q <= 1'b1;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      target_q    <= target_d;
      frames_q    <= frames_d;
      error_q     <= error_d;
      done_q      <= done_d;
      seq_reset_q <= seq_reset_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    target_d = target_q;
    frames_d = frames_q;
    error_d  = error_q;
    launch   = 1'b0;

    if (state_q == ST_IDLE) begin
      if (clear_i)     count_d = '0;
      else if (wr_acc) count_d = count_q + CW'(1);
    end

    case (state_q)
      ST_IDLE:  launch = start_ok;
      ST_PRE: begin
        if (abort_i) state_d = ST_IDLE;
        else if (hold_q == HW'(PRE_HOLD - 1)) begin
          state_d = ST_LOAD;
          ptr_d   = CW'(1);
          hold_d  = '0;
        end else hold_d = hold_q + HW'(1);
      end
      // ptr_q is the entry presented on the current edge; reaching count ends the burst.
      ST_LOAD: begin
        if (abort_i)               state_d = ST_IDLE;
        else if (ptr_q == count_q) state_d = ST_POST;
        else                       ptr_d   = ptr_q + CW'(1);
      end
      ST_POST: begin
        if (abort_i) state_d = ST_IDLE;
        else if (hold_q == HW'(POST_HOLD - 1)) begin
          state_d = ST_RUN;
          hold_d  = '0;
        end else hold_d = hold_q + HW'(1);
      end
      ST_RUN: begin
        if (seq_done_i) frames_d = frames_q + 16'd1;
        if (abort_i) state_d = ST_IDLE;
        else if (seq_done_i && (target_q != 16'd0) && (frames_d == target_q)) state_d = ST_IDLE;
        else if (wd_expired) begin
          state_d = ST_FAULT;
          error_d = 1'b1;
        end
      end
      ST_FAULT: begin
        if (abort_i) state_d = ST_IDLE;
        else         launch  = start_i;
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      if (count_d != '0) begin
        state_d  = ST_PRE;
        hold_d   = '0;
        ptr_d    = '0;
        frames_d = '0;
        error_d  = 1'b0;
        target_d = frame_count_i;
      end else begin
        state_d = ST_IDLE;
        error_d = 1'b1;
      end
    end
  end

  always_comb begin
    seq_reset_d = (state_d != ST_RUN);
    wen_d       = (state_d == ST_LOAD);
    wdata_d     = wen_d ? rd_data : wdata_q;
    done_d      = (state_q == ST_RUN) && (state_d == ST_IDLE) && !abort_i;
  end

  assign seq_reset_o     = seq_reset_q;
  assign seq_lut_wen_o   = wen_q;
  assign seq_lut_wdata_o = wdata_q;
  assign state_o         = state_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = done_q;
  assign error_o         = error_q;
  assign frames_done_o   = frames_q;

endmodule

// File: tb/tb_sequencer_ctrl.sv
// tb/tb_sequencer_ctrl.sv - scoreboard bench for sequencer_ctrl
module tb_sequencer_ctrl;
  import seq_ctrl_pkg::*;

  localparam int DEPTH = 16;
  localparam int PRE   = 4;
  localparam int POST  = 2;
  localparam int WDOG  = 100;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        cfg_valid_i, cfg_ready_o, clear_i, start_i, abort_i, seq_done_i;
  lut_entry_t  cfg_data_i, seq_lut_wdata_o;
  logic [15:0] frame_count_i, frames_done_o;
  logic        seq_reset_o, seq_lut_wen_o, busy_o, done_o, error_o;
  logic [2:0]  state_o;

  sequencer_ctrl #(
    .LUT_DEPTH(DEPTH), .PRE_HOLD(PRE), .POST_HOLD(POST), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .reset_n_i(reset_n_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_data_i(cfg_data_i), .clear_i(clear_i), .start_i(start_i), .abort_i(abort_i),
    .frame_count_i(frame_count_i), .seq_reset_o(seq_reset_o), .seq_lut_wen_o(seq_lut_wen_o),
    .seq_lut_wdata_o(seq_lut_wdata_o), .seq_done_i(seq_done_i), .state_o(state_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .frames_done_o(frames_done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    lut_entry_t data;
    int         at;
  } wr_exp_t;

  wr_exp_t    wq[$];
  wr_exp_t    mon_e;
  int         checks = 0, failures = 0;
  int         wr_seen = 0, done_seen = 0;
  lut_entry_t model_buf[DEPTH];
  int         model_cnt = 0;
  lut_entry_t prog[6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n_i) begin
      if (seq_lut_wen_o) begin
        if (wq.size() == 0) check("wen_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = wq.pop_front();
          check("wdata", seq_lut_wdata_o, mon_e.data);
          check("wen_cycle", cyc, mon_e.at);
        end
        wr_seen++;
      end
      if (done_o) done_seen++;
    end
  end

  task automatic write_entry(input lut_entry_t d);
    check("cfg_ready", cfg_ready_o, (model_cnt < DEPTH));
    cfg_valid_i = 1'b1;
    cfg_data_i  = d;
    if (model_cnt < DEPTH) begin
      model_buf[model_cnt] = d;
      model_cnt++;
    end
    @(negedge clk);
    cfg_valid_i = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] frames, output int k);
    start_i       = 1'b1;
    frame_count_i = frames;
    k             = cyc + 1;
    for (int i = 0; i < model_cnt; i++) wq.push_back('{model_buf[i], k + PRE + i});
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_run(input string tag, input int exp_edge);
    int n = 0;
    while (seq_reset_o !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, cyc, exp_edge);
  endtask

  task automatic pulse_done();
    seq_done_i = 1'b1;
    @(negedge clk);
    seq_done_i = 1'b0;
  endtask

  task automatic do_abort();
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
  endtask

  int k, base, r;

  initial begin
    prog[0] = pack_entry(1'b1, 1'b0, 16'd50,   8'd2, SEQ_PANEL_STABLE);
    prog[1] = pack_entry(1'b0, 1'b0, 16'd100,  8'd1, SEQ_BACK_BIAS);
    prog[2] = pack_entry(1'b0, 1'b0, 16'd400,  8'd4, SEQ_INTEGRATE);
    prog[3] = pack_entry(1'b0, 1'b0, 16'd30,   8'd1, SEQ_READ_SETUP);
    prog[4] = pack_entry(1'b0, 1'b0, 16'd1024, 8'd3, SEQ_READOUT);
    prog[5] = pack_entry(1'b0, 1'b1, 16'd20,   8'd1, SEQ_IDLE);

    reset_n_i = 1'b0; cfg_valid_i = 1'b0; cfg_data_i = '0; clear_i = 1'b0;
    start_i = 1'b0; abort_i = 1'b0; frame_count_i = '0; seq_done_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", state_o, ST_IDLE);
    check("rst_seq_reset", seq_reset_o, 1);
    check("rst_wen", seq_lut_wen_o, 0);
    check("rst_wdata", seq_lut_wdata_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ready", cfg_ready_o, 1);
    check("rst_error", error_o, 0);
    check("rst_frames", frames_done_o, 0);
    check("rst_done", done_o, 0);
    reset_n_i = 1'b1;
    @(negedge clk);

    // Full program, three frames.
    foreach (prog[i]) write_entry(prog[i]);
    do_start(16'd3, k);
    check("t1_busy", busy_o, 1);
    check("t1_state_pre", state_o, ST_PRE);
    wait_run("t1_run_edge", k + PRE + 6 + POST);
    check("t1_load_drained", wq.size(), 0);
    pulse_done();
    pulse_done();
    check("t1_frames2", frames_done_o, 2);
    check("t1_still_run", state_o, ST_RUN);
    pulse_done();
    check("t1_done", done_o, 1);
    check("t1_idle", state_o, ST_IDLE);
    check("t1_frames3", frames_done_o, 3);
    check("t1_seq_reset", seq_reset_o, 1);
    @(negedge clk);
    check("t1_done_pulse", done_o, 0);
    check("t1_done_count", done_seen, 1);

    // Abort after two LUT writes, then a clean reload.
    base = wr_seen;
    do_start(16'd1, k);
    repeat (5) @(negedge clk);
    do_abort();
    check("ab_wen", seq_lut_wen_o, 0);
    check("ab_state", state_o, ST_IDLE);
    check("ab_seq_reset", seq_reset_o, 1);
    check("ab_done", done_o, 0);
    check("ab_pending", wq.size(), 4);
    check("ab_writes", wr_seen - base, 2);
    wq.delete();
    do_start(16'd2, k);
    wait_run("ab_rerun_edge", k + PRE + 6 + POST);
    pulse_done();
    pulse_done();
    check("ab_rerun_done", done_o, 1);

    // Buffer overflow and clear.
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < 17; i++) write_entry(lut_entry_t'($urandom));
    check("ov_ready_full", cfg_ready_o, 0);
    clear_i = 1'b1; cfg_valid_i = 1'b1; cfg_data_i = prog[0];
    @(negedge clk);
    clear_i = 1'b0; cfg_valid_i = 1'b0;
    model_cnt = 0;
    check("ov_ready_clear", cfg_ready_o, 1);

    // Empty start flags an error; one entry then loads cleanly.
    do_start(16'd1, k);
    check("em_error", error_o, 1);
    check("em_busy", busy_o, 0);
    @(negedge clk);
    check("em_state", state_o, ST_IDLE);
    write_entry(prog[5]);
    do_start(16'd1, k);
    check("em_error_clr", error_o, 0);
    wait_run("em_run_edge", k + PRE + 1 + POST);
    pulse_done();
    check("em_done", done_o, 1);

    // Continuous mode wraps the frame counter.
    do_start(16'd0, k);
    wait_run("ct_run_edge", k + PRE + 1 + POST);
    seq_done_i = 1'b1;
    repeat (70000) @(negedge clk);
    check("ct_wrap", frames_done_o, 16'd4464);
    check("ct_run", state_o, ST_RUN);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0; seq_done_i = 1'b0;
    check("ct_abort_count", frames_done_o, 16'd4465);
    check("ct_abort_idle", state_o, ST_IDLE);
    check("ct_abort_nodone", done_o, 0);

`ifdef SEQ_CTRL_WATCHDOG_EN
    do_start(16'd5, k);
    wait_run("wd_run_edge", k + PRE + 1 + POST);
    r = cyc;
    begin
      int n = 0;
      while (state_o !== ST_FAULT && n < 300) begin
        @(negedge clk);
        n++;
      end
    end
    check("wd_fault", state_o, ST_FAULT);
    check("wd_edge", cyc, r + WDOG);
    check("wd_error", error_o, 1);
    check("wd_seq_reset", seq_reset_o, 1);
    do_start(16'd5, k);
    check("wd_restart", state_o, ST_PRE);
    check("wd_error_clr", error_o, 0);
    wait_run("wd_rerun_edge", k + PRE + 1 + POST);
    do_abort();
    check("wd_abort", state_o, ST_IDLE);
`else
    do_start(16'd5, k);
    wait_run("nw_run_edge", k + PRE + 1 + POST);
    repeat (200) @(negedge clk);
    check("nw_still_run", state_o, ST_RUN);
    check("nw_error", error_o, 0);
    do_abort();
    check("nw_abort", state_o, ST_IDLE);
`endif

    // Asynchronous reset mid-operation clears the entry count.
    do_start(16'd1, k);
    repeat (5) @(negedge clk);
    reset_n_i = 1'b0;
    #1;
    check("mr_state", state_o, ST_IDLE);
    check("mr_seq_reset", seq_reset_o, 1);
    check("mr_wen", seq_lut_wen_o, 0);
    wq.delete();
    @(negedge clk);
    reset_n_i = 1'b1;
    model_cnt = 0;
    @(negedge clk);
    do_start(16'd1, k);
    check("mr_count_cleared", error_o, 1);

    check("sb_empty", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequencer_ctrl.md
Name: sequencer_ctrl

Overview:
- Controller that owns the sequencer_fsm LUT load and run lifecycle.
- Host streams LUT entries (29-bit packed: sof[28], eof[27], data_length[26:11], repeat_count[10:3], next_state[2:0]) into an internal shadow buffer.
- On start: holds the sequencer in reset, replays the buffer through the sequencer write port, releases reset, and counts completed sequences until a target frame count or abort.
- Sits between the host register block and sequencer_fsm.

Parameters:
- LUT_DEPTH, 16: shadow buffer entries (power of 2).
- PRE_HOLD, 4: cycles of seq reset before the first LUT write (>=1).
- POST_HOLD, 2: cycles of seq reset after the last LUT write (>=1).
- WDOG_CYCLES, 65536: watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- cfg_valid_i  in  1  host entry valid
- cfg_ready_o  out  1  host entry accepted when valid&ready
- cfg_data_i  in  29  packed LUT entry
- clear_i  in  1  empty shadow buffer (IDLE only)
- start_i  in  1  start pulse
- abort_i  in  1  abort pulse
- frame_count_i  in  16  frames to run, latched at start; 0 = continuous
- seq_reset_o  out  1  active-high reset to sequencer_fsm
- seq_lut_wen_o  out  1  sequencer LUT write enable
- seq_lut_wdata_o  out  29  sequencer LUT write data
- seq_done_i  in  1  one-cycle pulse per completed sequence
- state_o  out  3  controller state
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse on normal completion
- error_o  out  1  sticky error, cleared by an accepted start
- frames_done_o  out  16  completed sequences since start

Behaviour:
- Reset values: state IDLE, entry count 0, seq_reset_o=1, seq_lut_wen_o=0, seq_lut_wdata_o=0, done_o=0, error_o=0, frames_done_o=0, busy_o=0. cfg_ready_o=1 after reset (IDLE, count 0).
- All outputs except cfg_ready_o and busy_o are registered.
- cfg_ready_o = (state==IDLE) && (count<LUT_DEPTH). An accepted write stores at index count, then count++. A write in the same cycle as start is stored and included in the load. Writes at count==LUT_DEPTH are refused (ready=0).
- clear_i in IDLE: count<=0; it wins over a same-cycle write. clear_i is ignored outside IDLE.
- States (state_o encoding):
  - IDLE=0: seq_reset_o=1.
  - PRE=1: seq_reset_o=1; lasts PRE_HOLD cycles.
  - LOAD=2: seq_reset_o=1, wen=1; one entry per cycle, index 0..N-1.
  - POST=3: seq_reset_o=1, wen=0; lasts POST_HOLD cycles.
  - RUN=4: seq_reset_o=0.
  - FAULT=5: seq_reset_o=1; exists only with the optional feature.
- Start in IDLE with N=count>0 (sampled at edge k):
  - frames_done_o<=0, error_o<=0, target latched.
  - wen high on cycles k+PRE_HOLD .. k+PRE_HOLD+N-1.
  - seq_reset_o falls at edge k+PRE_HOLD+N+POST_HOLD.
- Start with count==0: error_o<=1, stay IDLE.
- Start outside IDLE is ignored.
- RUN:
  - Each seq_done_i increments frames_done_o (16-bit, wraps in continuous mode).
  - When the incremented value equals a nonzero target: next edge returns to IDLE (seq_reset_o=1) and done_o pulses one cycle.
- abort_i in PRE/LOAD/POST/RUN/FAULT: next edge goes to IDLE; wen=0, seq_reset_o=1, no done_o. A partial load is discarded, since the sequencer reloads on the next start.
  - abort in IDLE: no effect; it beats a same-cycle start.
  - seq_done_i simultaneous with abort: the frame is counted, then abort.
- Shadow buffer contents survive runs; a restart reloads the same program.
- Reset mid-operation: immediate IDLE, count cleared, seq_reset_o=1.

Optional Feature:
- Macro: SEQ_CTRL_WATCHDOG_EN.
- Defined:
  - RUN cycle counter cleared on entry and on each seq_done_i.
  - Reaching WDOG_CYCLES-1 without seq_done_i → FAULT: error_o=1, seq_reset_o=1.
  - FAULT exits to IDLE only on abort_i or start_i; start_i restarts a load.
- Undefined: no counter, FAULT state unreachable, RUN waits indefinitely.

Decomposition:
- Package seq_ctrl_pkg:
  - State enum (3-bit encodings above).
  - LUT_ENTRY_W=29.
  - Field offset/width constants matching the packed entry layout.
  - Sequencer state codes RST..READOUT (0..7) for bench entry packing.
- Sub-module seq_ctrl_shadow_ram: LUT_DEPTH x 29 single-port-write, async-read register array.
- Controller FSM and counters stay in sequencer_ctrl.

Test Plan:
- Write 6 entries (PANEL_STABLE/2/50 … IDLE/1/20 eof=1), frame_count=3, start at edge k → wen high k+4..k+9 with entries in order, seq_reset_o low from edge k+12; after 3 seq_done pulses done_o pulses once, state IDLE, frames_done_o=3.
- Write 17 entries with LUT_DEPTH=16 → 16 accepted, cfg_ready_o=0 on the 17th; clear_i then restores cfg_ready_o=1 with count 0.
- Start with empty buffer → error_o=1, busy_o stays 0; next start after one write clears error_o and loads 1 entry.
- Abort during LOAD after 2 writes → wen=0 and IDLE next edge, seq_reset_o never deasserted, done_o=0; restart reloads all 6 entries.
- frame_count=0, 70000 seq_done pulses → frames_done_o wraps to 4464, stays RUN until abort; abort with simultaneous done_o-frame → count incremented before IDLE.
- SEQ_CTRL_WATCHDOG_EN, WDOG_CYCLES=100, no seq_done in RUN → FAULT on cycle 100, error_o=1, seq_reset_o=1; start_i reloads and clears error_o.
